fpu_align: RTL and testbench



---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/fpu_align_if.sv | 32 +++
 rtl/fpu_align_sticky_shr.sv | 26 ++
 rtl/fpu_align.sv | 151 +++++++++++++++
 tb/tb_fpu_align.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: mantissa/exponent widths, mantissa field
// positions, the align-stage FSM states and the IEEE-754 single unpack helper.
package fpu_pkg;

    localparam int MANT_W      = 28;
    localparam int EXP_W       = 8;
    localparam int SHIFT_W     = 5;

    // Internal mantissa layout: carry headroom, hidden bit, fraction, G/R/S.
    localparam int MANT_CARRY  = 27;
    localparam int MANT_HIDDEN = 26;
    localparam int MANT_STICKY = 0;

    localparam logic [EXP_W-1:0]   EXP_SPECIAL     = 8'hFF;
    localparam logic [SHIFT_W-1:0] MAX_ALIGN_SHIFT = 5'd27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } align_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [MANT_W-1:0] mant;
    } operand_t;

    // Split a single-precision word into sign, effective exponent and the
    // 28-bit internal mantissa. Denormals get exponent 1 and no hidden bit.
    function automatic operand_t unpack(input logic [31:0] f);
        operand_t u;
        u.sign                     = f[31];
        u.mant                     = '0;
        u.mant[MANT_CARRY]         = 1'b0;
        u.mant[MANT_HIDDEN]        = (f[30:23] != 8'h00);
        u.mant[MANT_HIDDEN-1 -: 23] = f[22:0];
        u.expo                     = (f[30:23] == 8'h00) ? 8'h01 : f[30:23];
        return u;
    endfunction

endpackage

// File: rtl/fpu_align_if.sv
// Handshake and data bundle between the operand source, the align stage and
// the adder. The align stage is the slave; the producer/consumer side is master.
interface fpu_align_if;
    import fpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] mantisa_a;
    logic [MANT_W-1:0] mantisa_b;
    logic [EXP_W-1:0]  exp_common;
    logic              sign_a;
    logic              sign_b;
    logic              swapped;
    logic              special;

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, mantisa_a, mantisa_b, exp_common,
               sign_a, sign_b, swapped, special
    );

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, mantisa_a, mantisa_b, exp_common,
               sign_a, sign_b, swapped, special
    );

endinterface

// File: rtl/fpu_align_sticky_shr.sv
// sticky_shr: combinational right shift of a 28-bit mantissa by 0..27 with
// every shifted-out bit ORed into the sticky position. Only built when
// FPU_ALIGN_BARREL_EN is defined; the serial align path does not need it.
`ifdef FPU_ALIGN_BARREL_EN
module sticky_shr
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0]  i_mant,
    input  logic [SHIFT_W-1:0] i_shamt,
    output logic [MANT_W-1:0]  o_mant
);

    logic [MANT_W-1:0] w_lost_mask;
    logic              w_sticky;

    assign w_lost_mask = (MANT_W'(1) << i_shamt) - MANT_W'(1);
    assign w_sticky    = |(i_mant & w_lost_mask);

    // Shift, then fold the discarded bits into the sticky position.
    always_comb begin
        o_mant              = i_mant >> i_shamt;
        o_mant[MANT_STICKY] = o_mant[MANT_STICKY] | w_sticky;
    end

endmodule
`endif

// File: rtl/fpu_align.sv
// fpu_align: unpack two singles, order them by magnitude and right-align the
// smaller mantissa to the larger exponent with sticky collection.
// Configuration macro FPU_ALIGN_BARREL_EN: defined = single-cycle barrel
// shift at accept; undefined = serial one-bit-per-cycle shift via SHIFT.
module fpu_align
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    fpu_align_if.slave bus
);

    operand_t           w_op_a;
    operand_t           w_op_b;
    operand_t           w_big;
    operand_t           w_small;
    logic               w_swap;
    logic               w_special;
    logic               w_accept;
    logic [EXP_W-1:0]   w_diff;
    logic [SHIFT_W-1:0] w_k;
    logic [MANT_W-1:0]  w_mant_b_init;

    align_state_e       r_state;
    align_state_e       w_next_state;
    logic [MANT_W-1:0]  r_mant_a;
    logic [MANT_W-1:0]  r_mant_b;
    logic [EXP_W-1:0]   r_exp;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_swapped;
    logic               r_special;
`ifndef FPU_ALIGN_BARREL_EN
    logic [SHIFT_W-1:0] r_count;
`endif

    assign w_op_a = unpack(bus.op_a);
    assign w_op_b = unpack(bus.op_b);

    // The hidden bit takes part in the compare so an exponent-1 normal
    // outranks a denormal that shares effective exponent 1. Ties keep op_a.
    assign w_swap  = {w_op_b.expo, w_op_b.mant} > {w_op_a.expo, w_op_a.mant};
    assign w_big   = w_swap ? w_op_b : w_op_a;
    assign w_small = w_swap ? w_op_a : w_op_b;

    assign w_special = (bus.op_a[30:23] == EXP_SPECIAL) ||
                       (bus.op_b[30:23] == EXP_SPECIAL);
    assign w_diff    = w_big.expo - w_small.expo;
    assign w_k       = w_special                             ? '0 :
                       (w_diff > EXP_W'(MAX_ALIGN_SHIFT))    ? MAX_ALIGN_SHIFT :
                                                               w_diff[SHIFT_W-1:0];

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

`ifdef FPU_ALIGN_BARREL_EN
    sticky_shr u_shr (
        .i_mant  (w_small.mant),
        .i_shamt (w_k),
        .o_mant  (w_mant_b_init)
    );
`else
    assign w_mant_b_init = w_small.mant;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
`ifdef FPU_ALIGN_BARREL_EN
                    w_next_state = ST_DONE;
`else
                    w_next_state = (w_k == '0) ? ST_DONE : ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
`ifdef FPU_ALIGN_BARREL_EN
                w_next_state = ST_DONE;
`else
                if (r_count == SHIFT_W'(1)) w_next_state = ST_DONE;
`endif
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Capture ordered operands on accept; serially align mantissa b in SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are cleared too, since the outputs
            // must read zero after reset, not just the control state.
            r_mant_a  <= '0;
            r_mant_b  <= '0;
            r_exp     <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_swapped <= 1'b0;
            r_special <= 1'b0;
`ifndef FPU_ALIGN_BARREL_EN
            r_count   <= '0;
`endif
        end else if (w_accept) begin
            r_mant_a  <= w_big.mant;
            r_mant_b  <= w_mant_b_init;
            r_exp     <= w_special ? EXP_SPECIAL : w_big.expo;
            r_sign_a  <= w_big.sign;
            r_sign_b  <= w_small.sign;
            r_swapped <= w_swap;
            r_special <= w_special;
`ifndef FPU_ALIGN_BARREL_EN
            r_count   <= w_k;
`endif
        end
`ifndef FPU_ALIGN_BARREL_EN
        else if (r_state == ST_SHIFT) begin
            // Bit 1 moves into bit 0 while the old bit 0 stays folded in.
            r_mant_b <= {1'b0, r_mant_b[MANT_W-1:1]} |
                        {{(MANT_W-1){1'b0}}, r_mant_b[MANT_STICKY]};
            r_count  <= r_count - SHIFT_W'(1);
        end
`endif
    end

    assign bus.mantisa_a  = r_mant_a;
    assign bus.mantisa_b  = r_mant_b;
    assign bus.exp_common = r_exp;
    assign bus.sign_a     = r_sign_a;
    assign bus.sign_b     = r_sign_b;
    assign bus.swapped    = r_swapped;
    assign bus.special    = r_special;

endmodule

// File: tb/tb_fpu_align.sv
// Directed + random bench for fpu_align. Expected results are pushed to a
// scoreboard queue when a pair is driven and popped when out_valid appears.
module tb_fpu_align;
    import fpu_pkg::*;

    typedef struct {
        logic [27:0] ma;
        logic [27:0] mb;
        logic [7:0]  e;
        logic        sa;
        logic        sb;
        logic        sw;
        logic        sp;
        int          lat;
    } exp_t;

`ifdef FPU_ALIGN_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    fpu_align_if bus();

    fpu_align dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [27:0] ma, input logic [27:0] mb,
                                input logic [7:0] e, input logic sa, input logic sb,
                                input logic sw, input logic sp, input int k);
        exp_t x;
        x.ma  = ma;
        x.mb  = mb;
        x.e   = e;
        x.sa  = sa;
        x.sb  = sb;
        x.sw  = sw;
        x.sp  = sp;
        x.lat = BARREL ? 0 : k;
        return x;
    endfunction

    // Reference: magnitude order from the raw exponent/fraction fields, the
    // alignment as a wide shift with the lost half reduced to a sticky bit.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, ebig, esml;
        logic [27:0] ma, mb, mbig, msml;
        logic [54:0] ext;
        logic        sw, sp;
        int          d, k;
        ea   = (a[30:23] == 8'h00) ? 8'h01 : a[30:23];
        eb   = (b[30:23] == 8'h00) ? 8'h01 : b[30:23];
        ma   = {1'b0, |a[30:23], a[22:0], 3'b000};
        mb   = {1'b0, |b[30:23], b[22:0], 3'b000};
        sw   = (b[30:0] > a[30:0]);
        sp   = (&a[30:23]) || (&b[30:23]);
        ebig = sw ? eb : ea;
        esml = sw ? ea : eb;
        mbig = sw ? mb : ma;
        msml = sw ? ma : mb;
        d    = int'(ebig) - int'(esml);
        k    = sp ? 0 : ((d > 27) ? 27 : d);
        ext  = {msml, 27'b0} >> k;
        return mk(mbig, ext[54:27] | {27'b0, |ext[26:0]}, sp ? 8'hFF : ebig,
                  sw ? b[31] : a[31], sw ? a[31] : b[31], sw, sp, k);
    endfunction

    task automatic check_outputs(input string tag, input exp_t x);
        check({tag, " mantisa_a"}, 32'(bus.mantisa_a), 32'(x.ma));
        check({tag, " mantisa_b"}, 32'(bus.mantisa_b), 32'(x.mb));
        check({tag, " exp_common"}, 32'(bus.exp_common), 32'(x.e));
        check({tag, " flags"}, {28'd0, bus.sign_a, bus.sign_b, bus.swapped, bus.special},
              {28'd0, x.sa, x.sb, x.sw, x.sp});
    endtask

    // Drive one pair, time its latency, compare against the scoreboard head,
    // optionally hold backpressure for 'hold' cycles, then release it.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input exp_t e, input int hold);
        exp_t x;
        int   lat;
        sb_q.push_back(e);
        @(negedge clk);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
        check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        x = sb_q.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(x.lat));
        check_outputs(tag, x);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " held out_valid/in_ready"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
            check_outputs({tag, " held"}, x);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " back to idle"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " out_valid/in_ready"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
        check({tag, " mantissas"}, 32'(bus.mantisa_a | bus.mantisa_b), 32'd0);
        check({tag, " exp/flags"}, {20'd0, bus.exp_common, bus.sign_a, bus.sign_b,
              bus.swapped, bus.special}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // Test-plan vectors with hand-derived expectations.
        run_vec("eq_exp",  32'h3F800000, 32'h3FC00000,
                mk(28'h6000000, 28'h4000000, 8'h7F, 0, 0, 1, 0, 0), 0);
        run_vec("d3",      32'h41000000, 32'h3F800001,
                mk(28'h4000000, 28'h0800001, 8'h82, 0, 0, 0, 0, 3), 5);
        run_vec("d100",    32'h71800000, 32'h0A000000,
                mk(28'h4000000, 28'h0000001, 8'hE3, 0, 0, 0, 0, 27), 0);
        run_vec("denorm",  32'h00000004, 32'h00800000,
                mk(28'h4000000, 28'h0000020, 8'h01, 0, 0, 1, 0, 0), 0);
        run_vec("inf_a",   32'h7F800000, 32'h3F800000,
                mk(28'h4000000, 28'h4000000, 8'hFF, 0, 0, 0, 1, 0), 0);
        run_vec("nan_b",   32'h3F800000, 32'hFFC00000,
                mk(28'h6000000, 28'h4000000, 8'hFF, 1, 0, 1, 1, 0), 0);
        run_vec("signs",   32'hC0000000, 32'h3F800000,
                mk(28'h4000000, 28'h2000000, 8'h80, 1, 0, 0, 0, 1), 0);
        run_vec("tie",     32'h3F800000, 32'hBF800000,
                mk(28'h4000000, 28'h4000000, 8'h7F, 0, 1, 0, 0, 0), 0);
        run_vec("sticky5", 32'h42000000, 32'h3F800001,
                mk(28'h4000000, 28'h0200001, 8'h84, 0, 0, 0, 0, 5), 0);
        run_vec("d26",     32'h4C800000, 32'h3F800000,
                mk(28'h4000000, 28'h0000001, 8'h99, 0, 0, 0, 0, 26), 0);
        run_vec("d27",     32'h3F800000, 32'h4D000000,
                mk(28'h4000000, 28'h0000001, 8'h9A, 0, 0, 1, 0, 27), 0);

        // Random pairs with nearby exponents, checked against the model.
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 31));
            run_vec("rand", ra, rb, model(ra, rb), 0);
        end

        // Asynchronous reset in the middle of a long alignment.
        @(negedge clk);
        bus.op_a     = 32'h71800000;
        bus.op_b     = 32'h0A000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid-shift out_valid/in_ready", {30'd0, bus.out_valid, bus.in_ready},
              {30'd0, BARREL, 1'b0});
        rst = 1'b1;
        #1;
        check_cleared("async reset");
        @(posedge clk);
        #1;
        check_cleared("reset held");
        @(negedge clk);
        rst = 1'b0;
        run_vec("after reset", 32'h41000000, 32'h3F800001,
                mk(28'h4000000, 28'h0800001, 8'h82, 0, 0, 0, 0, 3), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
